// File: rtl/dmem_responder.sv
// Data-side memory responder: zero-latency word loads, byte-lane stores, tohost and timer MMIO.
// Define DMEM_TIMER_EN to build the 64-bit prescaled timer with its compare interrupt.
module dmem_responder #(
   parameter int          RAM_AW    = 10,
   parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
   parameter              INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic [3:0]  amp,
   output logic [31:0] rdata,
   output logic        timer_irq,
   output logic        tohost_valid,
   output logic [31:0] tohost_data
);

   localparam int RAM_WORDS = 1 << RAM_AW;

   logic [31:0]       ram [RAM_WORDS];
   logic              ramSel;
   logic              mmioSel;
   logic [RAM_AW-1:0] wordIdx;
   logic [2:0]        mmioOff;
   logic [31:0]       alignedData;
   logic [31:0]       mmioRdata;
   logic              ramWrite;
   logic              mmioWrite;
   logic              wrTohost;
   logic [1:0]        unusedAddrBits;

   // Keep lanes whose enable is clear and take the new byte where it is set.
   function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  laneEn);
      logic [31:0] merged;
      merged = oldWord;
      for (int i = 0; i < 4; i++) begin
         if (laneEn[i]) merged[8*i +: 8] = newWord[8*i +: 8];
      end
      return merged;
   endfunction

   assign ramSel         = (addr[31:RAM_AW+2] == '0);
   assign mmioSel        = (addr[31:5] == MMIO_BASE[31:5]);
   assign wordIdx        = addr[RAM_AW+1:2];
   assign mmioOff        = addr[4:2];
   assign unusedAddrBits = addr[1:0];
   assign ramWrite       = we && ramSel && !reset;
   assign mmioWrite      = we && mmioSel && (amp != 4'b0000);
   assign wrTohost       = mmioWrite && (mmioOff == 3'd0);

   // The core hands over rs2 unshifted, so replicate the byte/halfword onto every lane it could target.
   always_comb begin
      alignedData = wdata;
      case (amp)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: alignedData = {4{wdata[7:0]}};
         4'b0011, 4'b1100:                   alignedData = {2{wdata[15:0]}};
         default:                            alignedData = wdata;
      endcase
   end

   // RAM is never reset; a store that lands while reset is held is discarded.
   always_ff @(posedge clk) begin
      if (ramWrite) begin
         for (int i = 0; i < 4; i++) begin
            if (amp[i]) ram[wordIdx][8*i +: 8] <= alignedData[8*i +: 8];
         end
      end
   end

   // tohost latches the merged store data and pulses valid for exactly the following cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tohost_valid <= 1'b0;
         tohost_data  <= 32'h0;
      end else begin
         tohost_valid <= wrTohost;
         if (wrTohost) tohost_data <= mergeLanes(tohost_data, alignedData, amp);
      end
   end

`ifdef DMEM_TIMER_EN
   localparam logic [2:0] OFF_MTIME_LO = 3'd2;
   localparam logic [2:0] OFF_MTIME_HI = 3'd3;
   localparam logic [2:0] OFF_CMP_LO   = 3'd4;
   localparam logic [2:0] OFF_CMP_HI   = 3'd5;
   localparam logic [2:0] OFF_PRESCALE = 3'd6;

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [15:0] prescale;
   logic [15:0] psc;
   logic        timerIrq;
   logic        tick;

   assign tick = (psc == prescale);

   // A store to one mtime half overrides that cycle's increment and leaves the other half untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mtime    <= 64'h0;
         mtimecmp <= '1;
         prescale <= 16'h0;
         psc      <= 16'h0;
         timerIrq <= 1'b0;
      end else begin
         timerIrq <= (mtime >= mtimecmp);
         if (mmioWrite && mmioOff == OFF_MTIME_LO)
            mtime <= {mtime[63:32], mergeLanes(mtime[31:0], alignedData, amp)};
         else if (mmioWrite && mmioOff == OFF_MTIME_HI)
            mtime <= {mergeLanes(mtime[63:32], alignedData, amp), mtime[31:0]};
         else if (tick)
            mtime <= mtime + 64'd1;
         if (mmioWrite && mmioOff == OFF_CMP_LO)
            mtimecmp[31:0] <= mergeLanes(mtimecmp[31:0], alignedData, amp);
         if (mmioWrite && mmioOff == OFF_CMP_HI)
            mtimecmp[63:32] <= mergeLanes(mtimecmp[63:32], alignedData, amp);
         if (mmioWrite && mmioOff == OFF_PRESCALE) begin
            if (amp[0]) prescale[7:0]  <= alignedData[7:0];
            if (amp[1]) prescale[15:8] <= alignedData[15:8];
            psc <= 16'h0;
         end else if (tick) begin
            psc <= 16'h0;
         end else begin
            psc <= psc + 16'd1;
         end
      end
   end

   always_comb begin
      mmioRdata = 32'h0;
      case (mmioOff)
         OFF_MTIME_LO: mmioRdata = mtime[31:0];
         OFF_MTIME_HI: mmioRdata = mtime[63:32];
         OFF_CMP_LO:   mmioRdata = mtimecmp[31:0];
         OFF_CMP_HI:   mmioRdata = mtimecmp[63:32];
         OFF_PRESCALE: mmioRdata = {16'h0, prescale};
         default:      mmioRdata = 32'h0;
      endcase
   end

   assign timer_irq = timerIrq;
`else
   assign mmioRdata = 32'h0;
   assign timer_irq = 1'b0;
`endif

   // Every cycle is a read; unmapped addresses return zero.
   always_comb begin
      rdata = 32'h0;
      if (ramSel)       rdata = ram[wordIdx];
      else if (mmioSel) rdata = mmioRdata;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; timer scenarios build only with DMEM_TIMER_EN.
module tb_dmem_responder;

   localparam logic [31:0] MMIO = 32'h1000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [3:0]  amp;
   logic [31:0] rdata;
   logic        timer_irq;
   logic        tohost_valid;
   logic [31:0] tohost_data;

   int checks   = 0;
   int failures = 0;

   dmem_responder dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .wdata        (wdata),
      .we           (we),
      .amp          (amp),
      .rdata        (rdata),
      .timer_irq    (timer_irq),
      .tohost_valid (tohost_valid),
      .tohost_data  (tohost_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One store cycle: drive the bus, let one rising edge commit it, then drop we 1ns later.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      addr  = a;
      wdata = d;
      amp   = m;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      we    = 1'b0;
      amp   = 4'b0000;
      wdata = 32'h0;
      addr  = MMIO;
      #1;
      checks++;
      if (tohost_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", tohost_valid); end
      checks++;
      if (tohost_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00000000", tohost_data); end
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq got=%b exp=0", timer_irq); end
`ifdef DMEM_TIMER_EN
      addr = MMIO + 32'h10;
      #1;
      checks++;
      if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL reset_cmp_lo got=%h exp=ffffffff", rdata); end
`endif
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_load_store();
      applyStimulus(32'h40, 32'hA1B2_C3D4, 4'b1111);
      addr = 32'h40;
      #1;
      checks++;
      if (rdata !== 32'hA1B2_C3D4) begin failures++; $display("[TB] FAIL lw_word got=%h exp=a1b2c3d4", rdata); end
      wdata = 32'h5555_5555;
      amp   = 4'b1111;
      we    = 1'b1;
      #1;
      checks++;
      if (rdata !== 32'hA1B2_C3D4) begin failures++; $display("[TB] FAIL read_before_write got=%h exp=a1b2c3d4", rdata); end
      @(posedge clk);
      #1;
      we = 1'b0;
      checks++;
      if (rdata !== 32'h5555_5555) begin failures++; $display("[TB] FAIL write_committed got=%h exp=55555555", rdata); end
      applyStimulus(32'h40, 32'hA1B2_C3D4, 4'b1111);
   endtask

   task automatic test_byte_lanes();
      applyStimulus(32'h42, 32'h0000_00EE, 4'b0100);
      addr = 32'h40;
      #1;
      checks++;
      if (rdata !== 32'hA1EE_C3D4) begin failures++; $display("[TB] FAIL sb_lane2 got=%h exp=a1eec3d4", rdata); end
      applyStimulus(32'h42, 32'h0000_1234, 4'b1100);
      addr = 32'h40;
      #1;
      checks++;
      if (rdata !== 32'h1234_C3D4) begin failures++; $display("[TB] FAIL sh_upper got=%h exp=1234c3d4", rdata); end
      applyStimulus(32'h40, 32'hFFFF_FFFF, 4'b0000);
      addr = 32'h40;
      #1;
      checks++;
      if (rdata !== 32'h1234_C3D4) begin failures++; $display("[TB] FAIL amp_zero got=%h exp=1234c3d4", rdata); end
      applyStimulus(32'h44, 32'h0000_0000, 4'b1111);
      applyStimulus(32'h47, 32'h0000_0077, 4'b1000);
      addr = 32'h44;
      #1;
      checks++;
      if (rdata !== 32'h7700_0000) begin failures++; $display("[TB] FAIL sb_lane3 got=%h exp=77000000", rdata); end
      applyStimulus(32'h44, 32'h0000_BEEF, 4'b0011);
      addr = 32'h44;
      #1;
      checks++;
      if (rdata !== 32'h7700_BEEF) begin failures++; $display("[TB] FAIL sh_lower got=%h exp=7700beef", rdata); end
   endtask

   task automatic test_tohost();
      applyStimulus(MMIO, 32'h0000_0001, 4'b1111);
      checks++;
      if (tohost_valid !== 1'b1) begin failures++; $display("[TB] FAIL tohost_pulse got=%b exp=1", tohost_valid); end
      checks++;
      if (tohost_data !== 32'h1) begin failures++; $display("[TB] FAIL tohost_data got=%h exp=00000001", tohost_data); end
      addr = MMIO;
      #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL tohost_reads_zero got=%h exp=00000000", rdata); end
      @(posedge clk);
      #1;
      checks++;
      if (tohost_valid !== 1'b0) begin failures++; $display("[TB] FAIL tohost_one_cycle got=%b exp=0", tohost_valid); end
      applyStimulus(MMIO, 32'h0000_000A, 4'b1111);
      applyStimulus(MMIO, 32'h0000_000B, 4'b1111);
      checks++;
      if (tohost_valid !== 1'b1 || tohost_data !== 32'hB) begin
         failures++; $display("[TB] FAIL tohost_b2b got=%b/%h exp=1/0000000b", tohost_valid, tohost_data);
      end
      @(posedge clk);
      #1;
      checks++;
      if (tohost_valid !== 1'b0) begin failures++; $display("[TB] FAIL tohost_b2b_end got=%b exp=0", tohost_valid); end
   endtask

`ifdef DMEM_TIMER_EN
   task automatic test_timer();
      bit found;
      applyStimulus(MMIO + 32'h14, 32'h0, 4'b1111);
      applyStimulus(MMIO + 32'h10, 32'h5, 4'b1111);
      applyStimulus(MMIO + 32'h18, 32'h3, 4'b1111);
      applyStimulus(MMIO + 32'h0C, 32'h0, 4'b1111);
      applyStimulus(MMIO + 32'h08, 32'h0, 4'b1111);
      addr = MMIO + 32'h08;
      #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL mtime_cleared got=%h exp=00000000", rdata); end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h1 || timer_irq !== 1'b0) begin
         failures++; $display("[TB] FAIL first_tick got=%h/%b exp=00000001/0", rdata, timer_irq);
      end
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h4) begin failures++; $display("[TB] FAIL presc_period got=%h exp=00000004", rdata); end
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h5 || timer_irq !== 1'b0) begin
         failures++; $display("[TB] FAIL reach_cmp got=%h/%b exp=00000005/0", rdata, timer_irq);
      end
      @(posedge clk);
      #1;
      checks++;
      if (timer_irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_rise got=%b exp=1", timer_irq); end
      addr = MMIO + 32'h18;
      #1;
      checks++;
      if (rdata !== 32'h3) begin failures++; $display("[TB] FAIL prescale_rd got=%h exp=00000003", rdata); end
      applyStimulus(MMIO + 32'h0C, 32'hFFFF_FFFF, 4'b1111);
      applyStimulus(MMIO + 32'h08, 32'hFFFF_FFFF, 4'b1111);
      addr = MMIO + 32'h08;
      #1;
      checks++;
      if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mtime_max got=%h exp=ffffffff", rdata); end
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(posedge clk);
         #1;
         if (rdata === 32'h0) found = 1'b1;
      end
      checks++;
      if (!found) begin failures++; $display("[TB] FAIL wrap_timeout got=%h exp=00000000", rdata); end
      addr = MMIO + 32'h0C;
      #1;
      checks++;
      if (rdata !== 32'h0 || timer_irq !== 1'b1) begin
         failures++; $display("[TB] FAIL wrap_hi got=%h/%b exp=00000000/1", rdata, timer_irq);
      end
      @(posedge clk);
      #1;
      checks++;
      if (timer_irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_drop got=%b exp=0", timer_irq); end
      applyStimulus(MMIO + 32'h10, 32'h0, 4'b1111);
      @(posedge clk);
      #1;
      checks++;
      if (timer_irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_cmp_zero got=%b exp=1", timer_irq); end
   endtask
`else
   task automatic test_timer_absent();
      applyStimulus(MMIO + 32'h18, 32'h3, 4'b1111);
      applyStimulus(MMIO + 32'h10, 32'h5, 4'b1111);
      addr = MMIO + 32'h18;
      #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL no_prescale got=%h exp=00000000", rdata); end
      addr = MMIO + 32'h10;
      #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL no_cmp got=%h exp=00000000", rdata); end
      repeat (3) @(posedge clk);
      addr = MMIO + 32'h08;
      #1;
      checks++;
      if (rdata !== 32'h0 || timer_irq !== 1'b0) begin
         failures++; $display("[TB] FAIL no_mtime got=%h/%b exp=00000000/0", rdata, timer_irq);
      end
   endtask
`endif

   task automatic test_async_reset();
      applyStimulus(MMIO, 32'h0000_0077, 4'b1111);
      addr = MMIO + 32'h08;
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (tohost_valid !== 1'b0 || tohost_data !== 32'h0) begin
         failures++; $display("[TB] FAIL async_tohost got=%b/%h exp=0/00000000", tohost_valid, tohost_data);
      end
      checks++;
      if (timer_irq !== 1'b0 || rdata !== 32'h0) begin
         failures++; $display("[TB] FAIL async_timer got=%b/%h exp=0/00000000", timer_irq, rdata);
      end
      addr  = 32'h40;
      wdata = 32'h0;
      amp   = 4'b1111;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (rdata !== 32'h1234_C3D4) begin failures++; $display("[TB] FAIL ram_kept got=%h exp=1234c3d4", rdata); end
   endtask

   task automatic test_unmapped();
      applyStimulus(32'h0, 32'h1111_1111, 4'b1111);
      applyStimulus(32'h0FFC, 32'h2222_2222, 4'b1111);
      addr = 32'h0FFC;
      #1;
      checks++;
      if (rdata !== 32'h2222_2222) begin failures++; $display("[TB] FAIL ram_top got=%h exp=22222222", rdata); end
      addr = 32'h2000_0000;
      #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL unmapped_rd got=%h exp=00000000", rdata); end
      applyStimulus(32'h2000_0000, 32'hDEAD_BEEF, 4'b1111);
      applyStimulus(32'h1000, 32'hCAFE_F00D, 4'b1111);
      addr = 32'h1000;
      #1;
      checks++;
      if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL past_ram_rd got=%h exp=00000000", rdata); end
      addr = 32'h0;
      #1;
      checks++;
      if (rdata !== 32'h1111_1111) begin failures++; $display("[TB] FAIL no_alias got=%h exp=11111111", rdata); end
      applyStimulus(MMIO + 32'h20, 32'h0000_0099, 4'b1111);
      checks++;
      if (tohost_valid !== 1'b0 || rdata !== 32'h0) begin
         failures++; $display("[TB] FAIL past_mmio got=%b/%h exp=0/00000000", tohost_valid, rdata);
      end
      addr = 32'h40;
      #1;
      checks++;
      if (rdata !== 32'h1234_C3D4) begin failures++; $display("[TB] FAIL ram_untouched got=%h exp=1234c3d4", rdata); end
   endtask

   initial begin
      test_reset();
      test_load_store();
      test_byte_lanes();
      test_tohost();
`ifdef DMEM_TIMER_EN
      test_timer();
`else
      test_timer_absent();
`endif
      test_async_reset();
      test_unmapped();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
